// File: rtl/cbus_rr_arbiter.sv
// cbus round-robin arbiter: locks one requester onto the shared master
// port for a whole burst and flags burst-length / dropped-request errors.
package cbus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int BEAT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] owner,
    output logic             proto_err
);

    localparam int CMP_W = ((BEAT_W > LEN_W) ? BEAT_W : LEN_W) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_proto_err;

    logic              w_found;
    logic [IDX_W-1:0]  w_sel;
    logic [IDX_W-1:0]  w_next_ptr;
    logic [CMP_W-1:0]  w_beats;
    logic [CMP_W-1:0]  w_expect;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!w_found &&
                ireqs[IDX_W'((int'(r_rr_ptr) + k) % NUM_INPUTS)].valid) begin
                w_found = 1'b1;
                w_sel   = IDX_W'((int'(r_rr_ptr) + k) % NUM_INPUTS);
            end
        end
    end

    assign w_next_ptr = (r_owner == IDX_W'(NUM_INPUTS - 1)) ?
                        '0 : r_owner + IDX_W'(1);

    // Widened so that len = max does not wrap to zero beats.
    assign w_beats  = CMP_W'(r_beat_cnt) + CMP_W'(1);
    assign w_expect = CMP_W'(ireqs[r_owner].len) + CMP_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_beat_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_found) begin
                r_owner    <= w_sel;
                r_beat_cnt <= '0;
                r_state    <= ST_BUSY;
            end
        end else begin
            if (!ireqs[r_owner].valid) begin
                r_proto_err <= 1'b1;
            end
            if (oresp.ready) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                if (oresp.last) begin
                    if (w_beats != w_expect) begin
                        r_proto_err <= 1'b1;
                    end
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        if (r_state == ST_BUSY) begin
            oreq            = ireqs[r_owner];
            iresps[r_owner] = oresp;
        end
    end

    assign busy      = (r_state == ST_BUSY);
    assign owner     = r_owner;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: grant latency, round-robin order,
// burst lock, length/drop errors and mid-burst reset.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [2];
    cbus_resp_t iresps [2];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [0:0] owner;
    logic       proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    cbus_rr_arbiter #(
        .NUM_INPUTS(2),
        .IDX_W(1),
        .BEAT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ireqs(ireqs),
        .iresps(iresps),
        .oreq(oreq),
        .oresp(oresp),
        .busy(busy),
        .owner(owner),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v,
                           input logic [7:0] len, input logic [31:0] addr);
        ireqs[idx].valid    = v;
        ireqs[idx].is_write = 1'b0;
        ireqs[idx].addr     = addr;
        ireqs[idx].len      = len;
        ireqs[idx].data     = 32'h0;
    endtask

    task automatic set_resp(input logic rdy, input logic lst,
                            input logic [31:0] d);
        oresp.ready = rdy;
        oresp.last  = lst;
        oresp.data  = d;
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 8'd0, 32'h0);
        set_req(1, 1'b0, 8'd0, 32'h0);
        set_resp(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset state, single I-side read
        do_reset();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_perr", 64'(proto_err), 64'd0);
        check("rst_oreq_v", 64'(oreq.valid), 64'd0);
        check("rst_iresp0", 64'(iresps[0]), 64'd0);
        check("rst_iresp1", 64'(iresps[1]), 64'd0);
        set_req(0, 1'b1, 8'd0, A0);
        #1;
        check("t1_idle_oreq_v", 64'(oreq.valid), 64'd0);
        tick();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_oreq_v", 64'(oreq.valid), 64'd1);
        check("t1_oreq_addr", 64'(oreq.addr), 64'(A0));
        check("t1_iresp0_rdy0", 64'(iresps[0].ready), 64'd0);
        set_resp(1'b1, 1'b1, 32'hCAFE_0001);
        #1;
        check("t1_iresp0", 64'(iresps[0]), {30'd0, 2'b11, 32'hCAFE_0001});
        check("t1_iresp1", 64'(iresps[1]), 64'd0);
        tick();
        set_req(0, 1'b0, 8'd0, A0);
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t1_done_busy", 64'(busy), 64'd0);
        check("t1_done_perr", 64'(proto_err), 64'd0);

        // 2: tie after reset, D-side 4-beat burst
        do_reset();
        set_req(0, 1'b1, 8'd0, A0);
        set_req(1, 1'b1, 8'd3, A1);
        tick();
        check("t2_owner0", 64'(owner), 64'd0);
        check("t2_oreq_addr0", 64'(oreq.addr), 64'(A0));
        set_resp(1'b1, 1'b1, 32'h1111_0000);
        #1;
        check("t2_iresp1_stall", 64'(iresps[1]), 64'd0);
        tick();
        set_req(0, 1'b0, 8'd0, A0);
        set_resp(1'b1, 1'b0, 32'h2222_0000);
        #1;
        check("t2_bubble_busy", 64'(busy), 64'd0);
        check("t2_bubble_oreq_v", 64'(oreq.valid), 64'd0);
        check("t2_idle_rdy0", 64'(iresps[0].ready), 64'd0);
        check("t2_idle_rdy1", 64'(iresps[1].ready), 64'd0);
        tick();
        check("t2_owner1", 64'(owner), 64'd1);
        check("t2_oreq_addr1", 64'(oreq.addr), 64'(A1));
        check("t2_oreq_len", 64'(oreq.len), 64'd3);
        for (int b = 0; b < 4; b++) begin
            set_resp(1'b1, b == 3, 32'h3333_0000 + 32'(b));
            #1;
            check("t2_beat_data", 64'(iresps[1].data), 64'(32'h3333_0000 + 32'(b)));
            check("t2_beat_rdy", 64'(iresps[1].ready), 64'd1);
            check("t2_beat_other", 64'(iresps[0]), 64'd0);
            check("t2_beat_busy", 64'(busy), 64'd1);
            tick();
        end
        set_req(1, 1'b0, 8'd0, A1);
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t2_done_busy", 64'(busy), 64'd0);
        check("t2_done_perr", 64'(proto_err), 64'd0);
        check("t2_done_owner", 64'(owner), 64'd1);

        // 3: port 0 re-asserts while port 1 waits
        set_req(0, 1'b1, 8'd0, A0);
        set_req(1, 1'b1, 8'd0, A1);
        tick();
        check("t3_owner0", 64'(owner), 64'd0);
        set_resp(1'b1, 1'b1, 32'h4444_0000);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t3_bubble", 64'(busy), 64'd0);
        tick();
        check("t3_owner1", 64'(owner), 64'd1);
        check("t3_busy1", 64'(busy), 64'd1);
        set_resp(1'b1, 1'b1, 32'h4444_0001);
        tick();
        set_req(1, 1'b0, 8'd0, A1);
        set_resp(1'b0, 1'b0, 32'h0);
        tick();
        check("t3_owner0_again", 64'(owner), 64'd0);
        check("t3_busy0_again", 64'(busy), 64'd1);
        set_resp(1'b1, 1'b1, 32'h4444_0002);
        tick();
        set_req(0, 1'b0, 8'd0, A0);
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t3_done_perr", 64'(proto_err), 64'd0);

        // 4: early last on a 4-beat burst
        set_req(0, 1'b1, 8'd3, A0);
        tick();
        check("t4_owner0", 64'(owner), 64'd0);
        set_resp(1'b1, 1'b0, 32'h5555_0000);
        tick();
        check("t4_perr_mid", 64'(proto_err), 64'd0);
        set_resp(1'b1, 1'b1, 32'h5555_0001);
        tick();
        set_req(0, 1'b0, 8'd0, A0);
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t4_perr", 64'(proto_err), 64'd1);
        check("t4_idle", 64'(busy), 64'd0);
        set_req(1, 1'b1, 8'd0, A1);
        tick();
        check("t4_owner1", 64'(owner), 64'd1);
        set_resp(1'b1, 1'b1, 32'h5555_0002);
        tick();
        set_req(1, 1'b0, 8'd0, A1);
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t4_perr_sticky", 64'(proto_err), 64'd1);

        // 5: reset on beat 2 of a 4-beat burst
        set_req(1, 1'b1, 8'd3, A1);
        tick();
        check("t5_owner1", 64'(owner), 64'd1);
        set_resp(1'b1, 1'b0, 32'h6666_0000);
        tick();
        set_resp(1'b1, 1'b0, 32'h6666_0001);
        reset = 1'b1;
        tick();
        check("t5_oreq_v", 64'(oreq.valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_owner", 64'(owner), 64'd0);
        check("t5_perr", 64'(proto_err), 64'd0);
        reset = 1'b0;
        set_resp(1'b0, 1'b0, 32'h0);
        set_req(0, 1'b1, 8'd0, A0);
        tick();
        check("t5_rrptr0_win", 64'(owner), 64'd0);
        set_resp(1'b1, 1'b1, 32'h6666_0002);
        tick();
        set_req(0, 1'b0, 8'd0, A0);
        set_req(1, 1'b0, 8'd0, A1);
        set_resp(1'b0, 1'b0, 32'h0);
        tick();

        // 6: owner drops valid mid-burst
        set_req(0, 1'b1, 8'd1, A0);
        tick();
        check("t6_owner0", 64'(owner), 64'd0);
        set_req(1, 1'b1, 8'd0, A1);
        set_req(0, 1'b0, 8'd1, A0);
        set_resp(1'b1, 1'b0, 32'h7777_0000);
        #1;
        check("t6_oreq_v_drop", 64'(oreq.valid), 64'd0);
        check("t6_busy_drop", 64'(busy), 64'd1);
        tick();
        check("t6_perr", 64'(proto_err), 64'd1);
        check("t6_locked_busy", 64'(busy), 64'd1);
        check("t6_locked_owner", 64'(owner), 64'd0);
        set_resp(1'b0, 1'b0, 32'h0);
        tick();
        check("t6_hold_owner", 64'(owner), 64'd0);
        check("t6_hold_iresp1", 64'(iresps[1]), 64'd0);
        set_resp(1'b1, 1'b1, 32'h7777_0001);
        tick();
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_perr_sticky", 64'(proto_err), 64'd1);
        tick();
        check("t6_owner1", 64'(owner), 64'd1);
        check("t6_busy1", 64'(busy), 64'd1);
        set_resp(1'b1, 1'b1, 32'h7777_0002);
        tick();
        set_req(1, 1'b0, 8'd0, A1);
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        check("t6_final_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
